// File: rtl/arp_rx_parser.sv
// Receive-side ARP request parser: validates a byte-stream ARP request for the local IP
// and pulses o_req with the captured sender MAC/IP. Define ARP_RX_CNT_EN for the frame counters.
module arp_rx_parser #(
    parameter bit ACCEPT_UNICAST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic [47:0] i_local_mac,
    input  logic [31:0] i_local_ip,
    output logic [47:0] o_mac,
    output logic [31:0] o_ip,
    output logic        o_req
`ifdef ARP_RX_CNT_EN
    ,
    output logic [15:0] o_rx_cnt,
    output logic [15:0] o_drop_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PARSE,
        S_PAD,
        S_DROP,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'd41;
    localparam logic [5:0] SAT_IDX  = 6'd42;

    state_t      state, state_n;
    logic [5:0]  idx, idx_n, eff_idx;
    logic        bc_ok, uc_ok, bc_n, uc_n;
    logic [7:0]  mac_b;
    logic        byte_pass;
    logic        parse_byte;
    logic        abort_evt;
    logic        drop_evt;
    logic        sh_mac_en, sh_ip_en;
    logic [47:0] sh_mac;
    logic [31:0] sh_ip;

    // A sof byte always restarts the frame at position 0, whatever the current index.
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        bc_n      = bc_ok;
        uc_n      = uc_ok;
        byte_pass = 1'b1;
        eff_idx   = i_rx_sof ? 6'd0 : idx;

        case (eff_idx)
            6'd0:    mac_b = i_local_mac[47:40];
            6'd1:    mac_b = i_local_mac[39:32];
            6'd2:    mac_b = i_local_mac[31:24];
            6'd3:    mac_b = i_local_mac[23:16];
            6'd4:    mac_b = i_local_mac[15:8];
            default: mac_b = i_local_mac[7:0];
        endcase

        if (eff_idx <= 6'd5) begin
            // Broadcast and unicast matches are tracked separately so a mixed address fails.
            bc_n      = (eff_idx == 6'd0 || bc_ok) && (i_rx_data == 8'hFF);
            uc_n      = ACCEPT_UNICAST && (eff_idx == 6'd0 || uc_ok) && (i_rx_data == mac_b);
            byte_pass = bc_n || uc_n;
        end else begin
            case (eff_idx)
                6'd12:   byte_pass = (i_rx_data == 8'h08);
                6'd13:   byte_pass = (i_rx_data == 8'h06);
                6'd14:   byte_pass = (i_rx_data == 8'h00);
                6'd15:   byte_pass = (i_rx_data == 8'h01);
                6'd16:   byte_pass = (i_rx_data == 8'h08);
                6'd17:   byte_pass = (i_rx_data == 8'h00);
                6'd18:   byte_pass = (i_rx_data == 8'h06);
                6'd19:   byte_pass = (i_rx_data == 8'h04);
                6'd20:   byte_pass = (i_rx_data == 8'h00);
                6'd21:   byte_pass = (i_rx_data == 8'h01);
                6'd38:   byte_pass = (i_rx_data == i_local_ip[31:24]);
                6'd39:   byte_pass = (i_rx_data == i_local_ip[23:16]);
                6'd40:   byte_pass = (i_rx_data == i_local_ip[15:8]);
                6'd41:   byte_pass = (i_rx_data == i_local_ip[7:0]);
                default: byte_pass = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        parse_byte = 1'b0;
        abort_evt  = 1'b0;
        drop_evt   = 1'b0;
        sh_mac_en  = 1'b0;
        sh_ip_en   = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_rx_valid && i_rx_sof) parse_byte = 1'b1;
            end
            S_PARSE: begin
                if (i_rx_valid) begin
                    parse_byte = 1'b1;
                    abort_evt  = i_rx_sof;
                end
            end
            S_PAD: begin
                if (i_rx_valid) begin
                    if (i_rx_sof) begin
                        parse_byte = 1'b1;
                        abort_evt  = 1'b1;
                    end else if (i_rx_eof) begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DROP: begin
                // The frame was already counted when it entered DROP.
                if (i_rx_valid) begin
                    if (i_rx_sof) parse_byte = 1'b1;
                    else if (i_rx_eof) state_n = S_IDLE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                if (i_rx_valid && i_rx_sof) parse_byte = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase

        if (parse_byte) begin
            idx_n     = (eff_idx == SAT_IDX) ? SAT_IDX : eff_idx + 6'd1;
            sh_mac_en = byte_pass && (eff_idx >= 6'd22) && (eff_idx <= 6'd27);
            sh_ip_en  = byte_pass && (eff_idx >= 6'd28) && (eff_idx <= 6'd31);
            if (!byte_pass) begin
                drop_evt = 1'b1;
                state_n  = i_rx_eof ? S_IDLE : S_DROP;
            end else if (eff_idx == LAST_IDX) begin
                state_n = i_rx_eof ? S_DONE : S_PAD;
            end else if (i_rx_eof) begin
                drop_evt = 1'b1;
                state_n  = S_IDLE;
            end else begin
                state_n = S_PARSE;
            end
        end
    end

    // NOTE: shadow registers are reset too; they are few flops and keep X out of o_mac/o_ip.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            bc_ok  <= 1'b0;
            uc_ok  <= 1'b0;
            sh_mac <= '0;
            sh_ip  <= '0;
            o_mac  <= '0;
            o_ip   <= '0;
            o_req  <= 1'b0;
        end else begin
            state <= state_n;
            o_req <= (state == S_DONE);
            if (parse_byte) begin
                idx   <= idx_n;
                bc_ok <= bc_n;
                uc_ok <= uc_n;
            end
            if (sh_mac_en) sh_mac <= {sh_mac[39:0], i_rx_data};
            if (sh_ip_en)  sh_ip  <= {sh_ip[23:0], i_rx_data};
            if (state == S_DONE) begin
                o_mac <= sh_mac;
                o_ip  <= sh_ip;
            end
        end
    end

`ifdef ARP_RX_CNT_EN
    // An sof-abort and a runt/failed new frame can land on the same byte: count both.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_cnt   <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (state == S_DONE) o_rx_cnt <= o_rx_cnt + 16'd1;
            o_drop_cnt <= o_drop_cnt + 16'(abort_evt) + 16'(drop_evt);
        end
    end
`endif

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: unicast-accepting and broadcast-only instances
// driven by the same stream, compared against a frame-level model of the ARP acceptance rules.
module tb_arp_rx_parser;

    typedef logic [7:0] frame_t[$];

    localparam logic [47:0] LM    = 48'h02ABCDEF0123;
    localparam logic [31:0] LIP   = 32'hC0A8010A;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic [47:0] mac_o [2];
    logic [31:0] ip_o [2];
    logic        req_o [2];
`ifdef ARP_RX_CNT_EN
    logic [15:0] rxc_o [2];
    logic [15:0] dropc_o [2];
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses [2];
    int          exp_pulses [2];
    logic [47:0] exp_mac [2];
    logic [31:0] exp_ip [2];
    logic [15:0] exp_rx [2];
    logic [15:0] exp_drop [2];

    always #5 clk = ~clk;

    arp_rx_parser #(.ACCEPT_UNICAST(1'b1)) u_dut_uc (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_rx_sof(rx_sof), .i_rx_eof(rx_eof), .i_local_mac(local_mac), .i_local_ip(local_ip),
        .o_mac(mac_o[0]), .o_ip(ip_o[0]), .o_req(req_o[0])
`ifdef ARP_RX_CNT_EN
        , .o_rx_cnt(rxc_o[0]), .o_drop_cnt(dropc_o[0])
`endif
    );

    arp_rx_parser #(.ACCEPT_UNICAST(1'b0)) u_dut_bc (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_rx_sof(rx_sof), .i_rx_eof(rx_eof), .i_local_mac(local_mac), .i_local_ip(local_ip),
        .o_mac(mac_o[1]), .o_ip(ip_o[1]), .o_req(req_o[1])
`ifdef ARP_RX_CNT_EN
        , .o_rx_cnt(rxc_o[1]), .o_drop_cnt(dropc_o[1])
`endif
    );

    // o_req is sampled at the edge that ends its high cycle.
    always @(posedge clk) begin
        if (req_o[0] === 1'b1) pulses[0]++;
        if (req_o[1] === 1'b1) pulses[1]++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void make_req(output frame_t f, input logic [47:0] dst,
                                     input logic [47:0] smac, input logic [31:0] sip,
                                     input logic [31:0] tip, input int len);
        logic [7:0] hdr [10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        f = {};
        for (int i = 0; i < 6; i++) f.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        for (int i = 0; i < 10; i++) f.push_back(hdr[i]);
        for (int i = 0; i < 6; i++) f.push_back(smac[47 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(sip[31 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
        for (int i = 0; i < 4; i++) f.push_back(tip[31 - 8*i -: 8]);
        while (f.size() < len) f.push_back(8'($urandom));
        while (f.size() > len) void'(f.pop_back());
    endfunction

    // Acceptance decided on the whole received frame.
    function automatic bit model_accept(input frame_t f, input bit uc);
        logic [7:0] hdr [10] = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
        bit bc_all, uc_all;
        if (f.size() < 42) return 1'b0;
        bc_all = 1'b1;
        uc_all = uc;
        for (int i = 0; i < 6; i++) begin
            if (f[i] != 8'hFF) bc_all = 1'b0;
            if (f[i] != LM[47 - 8*i -: 8]) uc_all = 1'b0;
        end
        if (!(bc_all || uc_all)) return 1'b0;
        for (int i = 0; i < 10; i++) if (f[12 + i] != hdr[i]) return 1'b0;
        for (int i = 0; i < 4; i++) if (f[38 + i] != LIP[31 - 8*i -: 8]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic account(input frame_t f, output logic [1:0] acc);
        logic [47:0] sm;
        logic [31:0] si;
        sm = '0;
        si = '0;
        if (f.size() >= 32) begin
            for (int i = 0; i < 6; i++) sm = {sm[39:0], f[22 + i]};
            for (int i = 0; i < 4; i++) si = {si[23:0], f[28 + i]};
        end
        for (int d = 0; d < 2; d++) begin
            acc[d] = model_accept(f, d == 0);
            if (acc[d]) begin
                exp_mac[d] = sm;
                exp_ip[d]  = si;
                exp_rx[d]++;
                exp_pulses[d]++;
            end else begin
                exp_drop[d]++;
            end
        end
    endtask

    task automatic send_bytes(input frame_t f, input int from, input int upto,
                              input bit with_eof, input bit gaps);
        for (int i = from; i < upto; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    rx_valid = 1'b0;
                    rx_data  = 8'($urandom);
                    rx_sof   = 1'($urandom);
                    rx_eof   = 1'($urandom);
                    tick();
                end
            end
            rx_valid = 1'b1;
            rx_data  = f[i];
            rx_sof   = (i == 0);
            rx_eof   = with_eof && (i == f.size() - 1);
            tick();
        end
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
    endtask

    // Called right after the eof byte's edge: o_req must rise one cycle later for one cycle.
    task automatic finish_frame(input frame_t f, input string tag);
        logic [1:0] acc;
        account(f, acc);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s_req_early[%0d]", tag, d), 64'(req_o[d]), 64'd0);
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_req[%0d]", tag, d), 64'(req_o[d]), 64'(acc[d]));
            check($sformatf("%s_mac[%0d]", tag, d), 64'(mac_o[d]), 64'(exp_mac[d]));
            check($sformatf("%s_ip[%0d]", tag, d), 64'(ip_o[d]), 64'(exp_ip[d]));
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_req_fall[%0d]", tag, d), 64'(req_o[d]), 64'd0);
            check($sformatf("%s_pulses[%0d]", tag, d), 64'(pulses[d]), 64'(exp_pulses[d]));
`ifdef ARP_RX_CNT_EN
            check($sformatf("%s_rx_cnt[%0d]", tag, d), 64'(rxc_o[d]), 64'(exp_rx[d]));
            check($sformatf("%s_drop_cnt[%0d]", tag, d), 64'(dropc_o[d]), 64'(exp_drop[d]));
`endif
        end
    endtask

    task automatic abort_frame();
        for (int d = 0; d < 2; d++) exp_drop[d]++;
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_mac[%0d]", tag, d), 64'(mac_o[d]), 64'd0);
            check($sformatf("%s_ip[%0d]", tag, d), 64'(ip_o[d]), 64'd0);
            check($sformatf("%s_req[%0d]", tag, d), 64'(req_o[d]), 64'd0);
`ifdef ARP_RX_CNT_EN
            check($sformatf("%s_rx_cnt[%0d]", tag, d), 64'(rxc_o[d]), 64'd0);
            check($sformatf("%s_drop_cnt[%0d]", tag, d), 64'(dropc_o[d]), 64'd0);
`endif
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_mac[d]  = '0;
            exp_ip[d]   = '0;
            exp_rx[d]   = '0;
            exp_drop[d] = '0;
        end
    endtask

    initial begin
        frame_t      fa, fb;
        logic [1:0]  acc;
        logic [47:0] dst;
        int          len, pos, k, kind;
        bit          gaps;

        rst       = 1'b1;
        rx_data   = '0;
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        rx_eof    = 1'b0;
        local_mac = LM;
        local_ip  = LIP;
        for (int d = 0; d < 2; d++) begin
            pulses[d]     = 0;
            exp_pulses[d] = 0;
        end
        model_reset();
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // Broadcast request from 00:11:22:33:44:55 / 192.168.1.2.
        make_req(fa, BCAST, 48'h001122334455, 32'hC0A80102, LIP, 60);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "bcast");
        check("bcast_mac_abs", 64'(mac_o[1]), 64'h001122334455);
        check("bcast_ip_abs", 64'(ip_o[1]), 64'hC0A80102);

        // Foreign target IP, wrong ethertype, reply opcode.
        make_req(fa, BCAST, 48'h0A0B0C0D0E0F, 32'hC0A80103, 32'hC0A8010B, 60);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "foreign_ip");
        check("foreign_mac_kept", 64'(mac_o[0]), 64'h001122334455);
        make_req(fa, BCAST, 48'h0A0B0C0D0E0F, 32'hC0A80103, LIP, 60);
        fa[13] = 8'h00;
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "ethertype");
        make_req(fa, BCAST, 48'h0A0B0C0D0E0F, 32'hC0A80103, LIP, 60);
        fa[21] = 8'h02;
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "reply_op");

        // Runts at 30 and 41 bytes; exactly 42 bytes is the shortest accepted frame.
        make_req(fa, BCAST, 48'h0A0B0C0D0E0F, 32'hC0A80103, LIP, 30);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "runt30");
        make_req(fa, BCAST, 48'h0A0B0C0D0E0F, 32'hC0A80103, LIP, 41);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "runt41");
        make_req(fa, BCAST, 48'h665544332211, 32'h0A000001, LIP, 42);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "len42");

        // sof at index 25 aborts the first frame; the second frame's sender wins.
        make_req(fa, BCAST, 48'hAAAAAAAAAAAA, 32'h01020304, LIP, 60);
        make_req(fb, BCAST, 48'h123456789ABC, 32'hC0A80177, LIP, 60);
        send_bytes(fa, 0, 25, 1'b0, 1'b0);
        abort_frame();
        send_bytes(fb, 0, fb.size(), 1'b1, 1'b0);
        finish_frame(fb, "abort25");
        check("abort25_mac_abs", 64'(mac_o[0]), 64'h123456789ABC);

        // Unicast to the local MAC, without and with gaps; a mixed address fails both.
        make_req(fa, LM, 48'h0000DEADBEEF, 32'hC0A80150, LIP, 60);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        finish_frame(fa, "ucast");
        make_req(fa, LM, 48'h0000CAFEF00D, 32'hC0A80151, LIP, 64);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b1);
        finish_frame(fa, "ucast_gaps");
        make_req(fa, {16'hFFFF, LM[31:0]}, 48'h0000CAFEF00E, 32'hC0A80152, LIP, 60);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b1);
        finish_frame(fa, "mixed_dst");

        // Next sof lands while the first frame is in its completion cycle.
        make_req(fa, BCAST, 48'h111111111111, 32'h0B0B0B0B, LIP, 42);
        make_req(fb, BCAST, 48'h222222222222, 32'h0C0C0C0C, LIP, 50);
        send_bytes(fa, 0, fa.size(), 1'b1, 1'b0);
        account(fa, acc);
        rx_valid = 1'b1;
        rx_data  = fb[0];
        rx_sof   = 1'b1;
        rx_eof   = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("b2b_req[%0d]", d), 64'(req_o[d]), 64'(acc[d]));
            check($sformatf("b2b_mac[%0d]", d), 64'(mac_o[d]), 64'h111111111111);
        end
        send_bytes(fb, 1, fb.size(), 1'b1, 1'b0);
        finish_frame(fb, "b2b_second");

        // Randomised frames: destination kind, corruption, truncation, aborts, gaps.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            dst  = (kind == 0) ? BCAST : (kind == 1) ? LM : {16'($urandom), 32'($urandom)};
            len  = $urandom_range(42, 64);
            make_req(fa, dst, {16'($urandom), 32'($urandom)}, 32'($urandom),
                     ($urandom_range(0, 5) == 0) ? (LIP ^ 32'd1) : LIP, len);
            if ($urandom_range(0, 2) == 0) begin
                pos = $urandom_range(0, fa.size() - 1);
                fa[pos] = fa[pos] ^ 8'($urandom_range(1, 255));
            end
            if ($urandom_range(0, 5) == 0) begin
                k = $urandom_range(1, 41);
                while (fa.size() > k) void'(fa.pop_back());
            end
            gaps = 1'($urandom_range(0, 1));
            if (n < 39 && $urandom_range(0, 5) == 0) begin
                send_bytes(fa, 0, $urandom_range(1, fa.size()), 1'b0, gaps);
                abort_frame();
            end else begin
                send_bytes(fa, 0, fa.size(), 1'b1, gaps);
                finish_frame(fa, "rnd");
            end
        end

        // Reset at index 35 of a valid request discards it; only the following request counts.
        make_req(fa, BCAST, 48'h333333333333, 32'h0D0D0D0D, LIP, 60);
        send_bytes(fa, 0, 35, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        model_reset();
        check_reset_state("mid_reset");
        rst = 1'b0;
        tick();
        make_req(fb, BCAST, 48'h444444444444, 32'h0E0E0E0E, LIP, 60);
        send_bytes(fb, 0, fb.size(), 1'b1, 1'b1);
        finish_frame(fb, "post_reset");
`ifdef ARP_RX_CNT_EN
        check("post_reset_rx_abs", 64'(rxc_o[0]), 64'd1);
        check("post_reset_drop_abs", 64'(dropc_o[0]), 64'd0);
`endif
        check("post_reset_mac_abs", 64'(mac_o[0]), 64'h444444444444);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arp_rx_parser.md
# arp_rx_parser

Receive-side ARP request parser ahead of the ARP response header writer. Consumes the byte-wide received Ethernet frame stream, validates an ARP request addressed to the local IP, and captures the requester's MAC/IP. It then issues a one-cycle request pulse so the response writer fills the reply header with those addresses. Non-ARP, malformed, runt or foreign-target frames are silently dropped.

## Interface
- ACCEPT_UNICAST, 1 — 1: destination MAC may be broadcast or i_local_mac; 0: broadcast only.

- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_rx_data  in  8  received frame byte
- i_rx_valid  in  1  i_rx_data valid this cycle; gaps allowed, no backpressure
- i_rx_sof  in  1  qualified by i_rx_valid; byte is frame byte 0
- i_rx_eof  in  1  qualified by i_rx_valid; byte is last frame byte (may coincide with sof)
- i_local_mac  in  48  local MAC, byte 0 in [47:40]
- i_local_ip  in  32  local IP, byte 0 in [31:24]
- o_mac  out  48  captured sender MAC, byte 0 in [47:40] (maps to mac0..mac5 of the response writer)
- o_ip  out  32  captured sender IP, byte 0 in [31:24] (maps to ip0..ip3)
- o_req  out  1  one-cycle pulse: valid request accepted, o_mac/o_ip updated
- o_rx_cnt  out  16  accepted-request count (ARP_RX_CNT_EN only)
- o_drop_cnt  out  16  dropped-frame count (ARP_RX_CNT_EN only)

## Operation
- States: IDLE, PARSE, PAD, DROP, DONE.
- IDLE: valid&sof -> PARSE with byte index 0 processed; valid without sof ignored.
- PARSE: 6-bit byte index idx, increments per valid byte, saturates at 42. Checks per idx:
  - 0–5: all 0xFF, or (ACCEPT_UNICAST) equal i_local_mac; either full match accepted, mixed not.
  - 6–11 ignored; 12–13 = 08 06; 14–15 = 00 01; 16–17 = 08 00; 18 = 06; 19 = 04; 20–21 = 00 01 (request only).
  - 22–27 captured into shadow sender-MAC; 28–31 into shadow sender-IP; 32–37 ignored; 38–41 = i_local_ip.
- Any check failure -> DROP (or IDLE if that byte is eof).
- Byte 41 passing with eof -> DONE; passing without eof -> PAD.
- eof at idx < 41 -> runt, dropped, IDLE.
- PAD: discard bytes until eof -> DONE.
- DROP: discard bytes until eof -> IDLE.
- DONE (one cycle): o_mac/o_ip <= shadow, o_req = 1, -> IDLE. Shadow registers never drive outputs directly; outputs change only on an accepted request.
- sof in PARSE/PAD/DROP: current frame counted dropped, new frame starts with this byte as idx 0. sof in DONE: DONE completes, byte parsed as idx 0 of new frame (next state PARSE).
- i_local_ip/i_local_mac sampled at the byte being compared; changes mid-frame need no special handling.
- i_rst anywhere: IDLE, partial frame discarded, nothing emitted.

## Timing
- Reset: o_mac=0, o_ip=0, o_req=0, counters=0, state IDLE.
- Latency: eof byte sampled at edge N -> o_req high cycle after edge N+1 with new o_mac/o_ip, low after N+2.
- Max request rate: one per frame; minimum accepted frame 42 bytes.
- o_req is a single-cycle pulse; consumer edge-detects it. Requests arriving while the consumer is busy are lost (ARP retries cover this).

## Configuration
- ARP_RX_CNT_EN defined: o_rx_cnt increments on each o_req; o_drop_cnt increments once per dropped frame (check fail, runt, sof-abort). Both wrap 0xFFFF->0.
- Undefined: both ports and counters absent; parse behaviour identical.

## Test plan
- Broadcast request, 60 bytes, target IP = local 192.168.1.10, sender 00:11:22:33:44:55 / 192.168.1.2 -> one o_req pulse two cycles after eof; o_mac=001122334455, o_ip=C0A80102.
- Same frame, target IP 192.168.1.11 -> no o_req, outputs unchanged, o_drop_cnt +1.
- Ethertype 0800, then opcode 0002 (reply) -> both dropped, no o_req.
- 30-byte frame ending mid-ARP -> dropped as runt; sof at idx 25 of a valid frame followed by full valid frame -> first dropped, second yields o_req with second frame's sender.
- Unicast to i_local_mac with ACCEPT_UNICAST=0 -> dropped; =1 -> accepted; valid deasserted randomly between bytes -> same results.
- i_rst asserted at idx 35 of a valid request, released, then new valid request -> only one o_req; (ARP_RX_CNT_EN) o_rx_cnt=1, o_drop_cnt=0.
